// File: rtl/flash_arbiter.sv
// Two-master round-robin arbiter in front of one flash controller port.
// Handles slave retry back-off, an optional retry limit, and owner aborts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; a request registered on the previous edge is granted
// ISSUE   | s_stb_o high toward the flash controller for the current owner
// BACKOFF | owner waits out the retry delay with s_stb_o low
// DONE    | one-cycle completion slot; ack/err pulse, owner released
module flash_arbiter #(
    parameter int RETRY_DELAY = 64,
    parameter int MAX_RETRY   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [23:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [23:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_rty_i,
    output logic [1:0]  grant_o
);

    localparam int          TW         = (RETRY_DELAY > 2) ? $clog2(RETRY_DELAY) : 1;
    localparam logic [TW-1:0] DELAY_LOAD = (RETRY_DELAY > 1) ? TW'(RETRY_DELAY - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BACKOFF = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          last, last_nxt;
    logic [7:0]    retry_cnt, retry_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [1:0]    req_q;
    logic [1:0]    req;
    logic [1:0]    ack, ack_nxt;
    logic [1:0]    err, err_nxt;
    logic          cap;
    logic          owner_stb;
    logic [7:0]    retry_inc;
    logic          limit_hit;

    // Requests are registered before arbitration; the live strobe still gates
    // them so a master that has already withdrawn is never granted.
    assign req       = req_q & {m1_stb_i, m0_stb_i};
    assign owner_stb = owner ? m1_stb_i : m0_stb_i;
    assign retry_inc = (retry_cnt == 8'hFF) ? 8'hFF : retry_cnt + 8'd1;
    assign limit_hit = (MAX_RETRY != 0) && (int'(retry_inc) == MAX_RETRY);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        retry_nxt = retry_cnt;
        timer_nxt = timer;
        ack_nxt   = 2'b00;
        err_nxt   = 2'b00;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = ISSUE;
                    retry_nxt = 8'd0;
                    timer_nxt = '0;
                    owner_nxt = (req == 2'b11) ? ~last : req[1];
                end
            end
            ISSUE: begin
                if (!owner_stb) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                    retry_nxt = 8'd0;
                end else if (s_ack_i) begin
                    cap            = 1'b1;
                    ack_nxt[owner] = 1'b1;
                    state_nxt      = DONE;
                end else if (s_rty_i) begin
                    retry_nxt = retry_inc;
                    if (limit_hit) begin
                        err_nxt[owner] = 1'b1;
                        state_nxt      = DONE;
                    end else begin
                        timer_nxt = DELAY_LOAD;
                        state_nxt = BACKOFF;
                    end
                end
            end
            BACKOFF: begin
                if (!owner_stb) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                    retry_nxt = 8'd0;
                end else if (timer == '0) begin
                    state_nxt = ISSUE;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                last_nxt  = owner;
                retry_nxt = 8'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            retry_cnt <= 8'd0;
            timer     <= '0;
            req_q     <= 2'b00;
            ack       <= 2'b00;
            err       <= 2'b00;
            m0_dat_o  <= 32'd0;
            m1_dat_o  <= 32'd0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            retry_cnt <= retry_nxt;
            timer     <= timer_nxt;
            req_q     <= {m1_stb_i, m0_stb_i};
            ack       <= ack_nxt;
            err       <= err_nxt;
            if (cap && !owner) m0_dat_o <= s_dat_i;
            if (cap && owner)  m1_dat_o <= s_dat_i;
        end
    end

    assign m0_ack_o = ack[0];
    assign m1_ack_o = ack[1];
    assign m0_err_o = err[0];
    assign m1_err_o = err[1];

    // Strobe and grant decode straight from state so reset drops them at once.
    assign s_stb_o = (state == ISSUE);

    always_comb begin
        grant_o = 2'b00;
        if (state == ISSUE || state == BACKOFF) begin
            grant_o = owner ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        s_adr_o = 24'd0;
        s_dat_o = 32'd0;
        s_we_o  = 1'b0;
        if (grant_o[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
        end else if (grant_o[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: slave response plan, completion scoreboard,
// chip-select gap monitor and reset checks.
module tb_flash_arbiter;

    localparam int RETRY_DELAY = 4;
    localparam int MAX_RETRY   = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] m0_adr_i = '0, m1_adr_i = '0;
    logic [31:0] m0_dat_i = '0, m1_dat_i = '0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic        m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [23:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o, s_stb_o;
    logic [31:0] s_dat_i = 32'h0BAD_F00D;
    logic        s_ack_i = 1'b0, s_rty_i = 1'b0;
    logic [1:0]  grant_o;

    flash_arbiter #(.RETRY_DELAY(RETRY_DELAY), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_rty_i(s_rty_i), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Slave model: one planned response per s_stb_o burst.
    typedef struct {int wait_n; bit rty; logic [31:0] data;} resp_t;
    resp_t plan_q[$];
    resp_t sl_cur;
    bit    sl_busy = 1'b0;
    int    sl_cnt = 0;

    always @(negedge clk_i) begin
        s_ack_i = 1'b0;
        s_rty_i = 1'b0;
        s_dat_i = 32'h0BAD_F00D;
        if (!s_stb_o) begin
            sl_busy = 1'b0;
        end else begin
            if (!sl_busy && plan_q.size() > 0) begin
                sl_cur  = plan_q.pop_front();
                sl_busy = 1'b1;
                sl_cnt  = 0;
            end
            if (sl_busy) begin
                sl_cnt++;
                if (sl_cnt == sl_cur.wait_n) begin
                    if (sl_cur.rty) s_rty_i = 1'b1;
                    else begin
                        s_ack_i = 1'b1;
                        s_dat_i = sl_cur.data;
                    end
                end
            end
        end
    end

    // Scoreboard: expected completions in order, checked when a pulse appears.
    typedef struct {bit mst; bit err; logic [31:0] data;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] mdl_dat [2];

    always @(negedge clk_i) begin
        logic [3:0] pulses;
        logic [3:0] want;
        exp_t       e;
        pulses = {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};
        if (pulses != 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 64'(pulses), 64'd0);
            end else begin
                e    = exp_q.pop_front();
                want = 4'b0001 << {e.mst, e.err};
                if (!e.err) mdl_dat[e.mst] = e.data;
                chk("sb_pulse", 64'(pulses), 64'(want));
                chk("sb_data", {m1_dat_o, m0_dat_o}, {mdl_dat[1], mdl_dat[0]});
            end
        end
    end

    // Chip select must stay high (s_stb_o low) for at least one full cycle.
    logic h1 = 1'b0, h2 = 1'b0;
    int   gap_viol = 0;
    always @(negedge clk_i) begin
        if (h2 && !h1 && s_stb_o) gap_viol++;
        h2 = h1;
        h1 = s_stb_o;
    end

    int          gaps[$];
    int          bursts, lat, grant_at, rise_at, done_who;
    logic [1:0]  grant_rise;
    logic [23:0] adr_rise;
    logic [31:0] wdat_rise;
    logic        we_rise;

    // who: 0/1 = that master, 2 = whichever completes first. Drops its stb on completion.
    task automatic wait_done(input int who, input int budget, input string tag);
        bit prev;
        bit hit;
        int lows;
        gaps.delete();
        bursts = 0; lat = -1; grant_at = -1; rise_at = -1; done_who = -1;
        lows = 0; hit = 1'b0; prev = s_stb_o;
        for (int n = 1; n <= budget && !hit; n++) begin
            tick();
            if (grant_at < 0 && grant_o != 2'b00) grant_at = n;
            if (s_stb_o && !prev) begin
                bursts++;
                if (bursts == 1) begin
                    rise_at    = n;
                    grant_rise = grant_o;
                    adr_rise   = s_adr_o;
                    wdat_rise  = s_dat_o;
                    we_rise    = s_we_o;
                end else begin
                    gaps.push_back(lows);
                end
                lows = 0;
            end else if (!s_stb_o) begin
                lows++;
            end
            prev = s_stb_o;
            if (who != 1 && (m0_ack_o || m0_err_o)) begin
                hit = 1'b1; done_who = 0; m0_stb_i = 1'b0;
            end else if (who != 0 && (m1_ack_o || m1_err_o)) begin
                hit = 1'b1; done_who = 1; m1_stb_i = 1'b0;
            end
            if (hit) lat = n - rise_at;
        end
        chk({tag, "_completed"}, 64'(hit), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        mdl_dat[0] = 32'd0;
        mdl_dat[1] = 32'd0;

        // Reset state, with a non-zero address present on an idle master.
        m0_adr_i = 24'h123456;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_ctrl", 64'({s_stb_o, grant_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o}), 64'd0);
        chk("reset_dat", {m1_dat_o, m0_dat_o}, 64'd0);
        chk("reset_bus", 64'({s_adr_o, s_dat_o}), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Simultaneous requests twice: m0, m1, m0, m1.
        plan_q.push_back('{2, 1'b0, 32'h1111_0000});
        plan_q.push_back('{2, 1'b0, 32'h2222_0001});
        plan_q.push_back('{2, 1'b0, 32'h3333_0002});
        plan_q.push_back('{2, 1'b0, 32'h4444_0003});
        exp_q.push_back('{1'b0, 1'b0, 32'h1111_0000});
        exp_q.push_back('{1'b1, 1'b0, 32'h2222_0001});
        exp_q.push_back('{1'b0, 1'b0, 32'h3333_0002});
        exp_q.push_back('{1'b1, 1'b0, 32'h4444_0003});
        m0_adr_i = 24'h000010;
        m1_adr_i = 24'h000020;
        m0_stb_i = 1'b1;
        m1_stb_i = 1'b1;
        wait_done(2, 40, "rr1a");
        chk("rr1a_who", 64'(done_who), 64'd0);
        chk("rr1a_bus", 64'({grant_rise, adr_rise}), 64'({2'b01, 24'h000010}));
        wait_done(2, 40, "rr1b");
        chk("rr1b_who", 64'(done_who), 64'd1);
        chk("rr1b_bus", 64'({grant_rise, adr_rise}), 64'({2'b10, 24'h000020}));
        tick();
        m0_stb_i = 1'b1;
        m1_stb_i = 1'b1;
        wait_done(2, 40, "rr2a");
        chk("rr2a_who", 64'(done_who), 64'd0);
        wait_done(2, 40, "rr2b");
        chk("rr2b_who", 64'(done_who), 64'd1);
        tick();
        tick();

        // Single m0 read, slave acks 5 cycles after s_stb_o rises.
        plan_q.push_back('{5, 1'b0, 32'hA5A5_A5A5});
        exp_q.push_back('{1'b0, 1'b0, 32'hA5A5_A5A5});
        m0_adr_i = 24'h000100;
        m0_we_i  = 1'b0;
        m0_stb_i = 1'b1;
        wait_done(0, 40, "read");
        chk("read_grant_latency", 64'({grant_at, rise_at}), 64'({32'd2, 32'd2}));
        chk("read_bus", 64'({grant_rise, adr_rise, we_rise}), 64'({2'b01, 24'h000100, 1'b0}));
        chk("read_ack_latency", 64'(lat), 64'd5);
        chk("read_done_state", 64'({grant_o, s_stb_o}), 64'd0);
        tick();

        // m1: rty, rty, ack with RETRY_DELAY = 4.
        plan_q.push_back('{1, 1'b1, 32'h0});
        plan_q.push_back('{1, 1'b1, 32'h0});
        plan_q.push_back('{2, 1'b0, 32'hCAFE_0034});
        exp_q.push_back('{1'b1, 1'b0, 32'hCAFE_0034});
        m1_adr_i = 24'h00ABCD;
        m1_stb_i = 1'b1;
        wait_done(1, 80, "retry");
        chk("retry_bursts", 64'(bursts), 64'd3);
        chk("retry_gap_count", 64'(gaps.size()), 64'd2);
        for (int i = 0; i < 2; i++) chk("retry_gap_len", 64'(gaps[i]), 64'(RETRY_DELAY));
        chk("retry_bus", 64'({grant_rise, adr_rise}), 64'({2'b10, 24'h00ABCD}));
        tick();
        chk("retry_single_ack", 64'({m1_ack_o, m1_err_o}), 64'd0);

        // MAX_RETRY = 3, slave always retries: three bursts then m0_err_o.
        plan_q.push_back('{1, 1'b1, 32'h0});
        plan_q.push_back('{1, 1'b1, 32'h0});
        plan_q.push_back('{1, 1'b1, 32'h0});
        exp_q.push_back('{1'b0, 1'b1, 32'h0});
        m0_adr_i = 24'h0F0F0F;
        m0_dat_i = 32'h5555_AAAA;
        m0_we_i  = 1'b1;
        m0_stb_i = 1'b1;
        wait_done(0, 80, "maxrty");
        chk("maxrty_bursts", 64'(bursts), 64'd3);
        chk("maxrty_kind", 64'({m0_err_o, m0_ack_o}), 64'({1'b1, 1'b0}));
        chk("maxrty_write_bus", 64'({we_rise, wdat_rise}), 64'({1'b1, 32'h5555_AAAA}));
        m0_we_i = 1'b0;
        tick();

        // m1 abandons during BACKOFF; waiting m0 is served next.
        plan_q.push_back('{1, 1'b1, 32'h0});
        m1_adr_i = 24'h000361;
        m1_stb_i = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (grant_o == 2'b10 && !s_stb_o) found = 1'b1;
        end
        chk("abort_reached_backoff", 64'(found), 64'd1);
        plan_q.push_back('{1, 1'b0, 32'h3636_3636});
        exp_q.push_back('{1'b0, 1'b0, 32'h3636_3636});
        m0_adr_i = 24'h000036;
        m0_stb_i = 1'b1;
        m1_stb_i = 1'b0;
        tick();
        chk("abort_idle", 64'({grant_o, s_stb_o}), 64'd0);
        tick();
        chk("abort_m0_next", 64'({grant_o, s_stb_o, s_adr_o}), 64'({2'b01, 1'b1, 24'h000036}));
        wait_done(0, 40, "abort_m0");
        tick();

        // Reset while s_stb_o is high.
        plan_q.push_back('{20, 1'b0, 32'hDEAD_0037});
        m0_adr_i = 24'h000037;
        m0_stb_i = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (s_stb_o) found = 1'b1;
        end
        chk("rst_reached_issue", 64'(found), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_ctrl", 64'({s_stb_o, grant_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'd0);
        chk("rst_async_dat", {m1_dat_o, m0_dat_o}, 64'd0);
        chk("rst_async_bus", 64'({s_adr_o, s_dat_o, s_we_o}), 64'd0);
        m0_stb_i   = 1'b0;
        mdl_dat[0] = 32'd0;
        mdl_dat[1] = 32'd0;
        plan_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (6) tick();
        chk("post_reset_idle", 64'({grant_o, s_stb_o}), 64'd0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("cs_gap_violations", 64'(gap_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
